// File: rtl/vector_xor_accumulator_if.sv
// Word-stream handshake between an upstream word source (master) and the
// XOR reduction block (slave).
interface vector_xor_accumulator_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
);
    logic                    START;
    logic                    READY;
    logic [CONTROL_SIZE-1:0] SIZE_IN;
    logic                    DATA_IN_ENABLE;
    logic                    DATA_ENABLE;
    logic [DATA_SIZE-1:0]    DATA_IN;
    logic [DATA_SIZE-1:0]    DATA_OUT;

    modport master (
        output START,
        output SIZE_IN,
        output DATA_IN_ENABLE,
        output DATA_IN,
        input  READY,
        input  DATA_ENABLE,
        input  DATA_OUT
    );

    modport slave (
        input  START,
        input  SIZE_IN,
        input  DATA_IN_ENABLE,
        input  DATA_IN,
        output READY,
        output DATA_ENABLE,
        output DATA_OUT
    );
endinterface

// File: rtl/vector_xor_accumulator.sv
// Folds a stream of SIZE_IN words into one word by bitwise XOR, requesting
// each word with a DATA_ENABLE pulse and flagging the result with READY.
module vector_xor_accumulator #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input logic                   CLK,
    input logic                   RST,
    vector_xor_accumulator_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        INPUT = 1'b1
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] CNT_ONE = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [CONTROL_SIZE-1:0] counter_q;
    logic [CONTROL_SIZE-1:0] size_q;
    logic [DATA_SIZE-1:0]    acc_q;
    logic [DATA_SIZE-1:0]    data_out_q;
    logic                    ready_q;
    logic                    data_en_q;

    logic [CONTROL_SIZE-1:0] last_idx_d;
    logic [DATA_SIZE-1:0]    acc_d;
    logic                    last_word_d;
    logic                    size_zero_d;

    // size_q is never zero in INPUT, so size_q-1 cannot wrap; a full-range
    // SIZE_IN simply compares against all-ones-minus-one.
    assign last_idx_d  = size_q - CNT_ONE;
    assign last_word_d = (counter_q == last_idx_d);
    assign acc_d       = acc_q ^ bus.DATA_IN;
    assign size_zero_d = (bus.SIZE_IN == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            size_q     <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            data_en_q  <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            data_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        if (size_zero_d) begin
                            // An empty vector folds to zero immediately.
                            ready_q    <= 1'b1;
                            data_out_q <= '0;
                        end else begin
                            size_q    <= bus.SIZE_IN;
                            acc_q     <= '0;
                            counter_q <= '0;
                            data_en_q <= 1'b1;
                            state_q   <= INPUT;
                        end
                    end
                end
                INPUT: begin
                    // Words are taken whenever they arrive, not only right
                    // after a request, so a slow upstream never stalls us.
                    if (bus.DATA_IN_ENABLE) begin
                        if (last_word_d) begin
                            data_out_q <= acc_d;
                            ready_q    <= 1'b1;
                            counter_q  <= '0;
                            state_q    <= IDLE;
                        end else begin
                            acc_q     <= acc_d;
                            counter_q <= counter_q + CNT_ONE;
                            data_en_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.READY       = ready_q;
    assign bus.DATA_ENABLE = data_en_q;
    assign bus.DATA_OUT    = data_out_q;

endmodule

// File: tb/tb_vector_xor_accumulator.sv
// Bench for vector_xor_accumulator: scoreboarded XOR reductions covering
// reset, empty vectors, ignored restarts, aborts, back-to-back runs and max size.
module tb_vector_xor_accumulator;

    localparam int DW = 8;
    localparam int CW = 8;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    vector_xor_accumulator_if #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) bus ();

    vector_xor_accumulator #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int de_count = 0;
    int ready_count = 0;
    logic [DW-1:0] sb[$];

    always @(negedge CLK) begin
        if (bus.DATA_ENABLE === 1'b1) de_count++;
        if (bus.READY === 1'b1) ready_count++;
    end

    task automatic do_start(input logic [CW-1:0] n);
        bus.SIZE_IN = n;
        bus.START   = 1'b1;
        @(negedge CLK);
        bus.START   = 1'b0;
    endtask

    // Waits for a word request, optionally idles gap cycles, then presents w.
    task automatic feed_word(input logic [DW-1:0] w, input int gap, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.DATA_ENABLE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) return;
        repeat (gap) @(negedge CLK);
        bus.DATA_IN        = w;
        bus.DATA_IN_ENABLE = 1'b1;
        @(negedge CLK);
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = DW'($urandom);
    endtask

    task automatic wait_ready(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.READY === 1'b1) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_power_on_reset;
        checks++;
        if ({bus.READY, bus.DATA_ENABLE, bus.DATA_OUT} !== {2'b00, {DW{1'b0}}})
            $display("FAIL por_outputs: got %b/%b/%h expected 0/0/00", bus.READY, bus.DATA_ENABLE, bus.DATA_OUT);
        else passes++;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.READY, bus.DATA_ENABLE, bus.DATA_OUT} !== {2'b00, {DW{1'b0}}})
            $display("FAIL por_idle: got %b/%b/%h expected 0/0/00", bus.READY, bus.DATA_ENABLE, bus.DATA_OUT);
        else passes++;
    endtask

    task automatic test_basic;
        logic [DW-1:0] words [3];
        logic [DW-1:0] exp;
        bit ok, all_ok;
        int lat, de0;
        words = '{8'h0F, 8'hF0, 8'h55};
        de0 = de_count;
        all_ok = 1'b1;
        do_start(CW'(3));
        for (int i = 0; i < 3; i++) begin
            if (i == 2) sb.push_back(words[0] ^ words[1] ^ words[2]);
            feed_word(words[i], 0, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok) $display("FAIL basic_request: got timeout expected DATA_ENABLE per word");
        else passes++;
        wait_ready(ok, lat);
        checks++;
        if (!ok) begin
            $display("FAIL basic_ready: got no READY expected pulse");
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL basic_data: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
        checks++;
        if (lat != 0) $display("FAIL basic_latency: got %0d expected 0", lat);
        else passes++;
        repeat (3) @(negedge CLK);
        checks++;
        if (de_count - de0 != 3) $display("FAIL basic_de_pulses: got %0d expected 3", de_count - de0);
        else passes++;
        checks++;
        if (bus.DATA_OUT !== 8'hAA) $display("FAIL basic_hold: got %h expected aa", bus.DATA_OUT);
        else passes++;
    endtask

    task automatic test_async_reset;
        do_start(CW'(2));
        checks++;
        if (bus.DATA_ENABLE !== 1'b1) $display("FAIL arst_pre_de: got %b expected 1", bus.DATA_ENABLE);
        else passes++;
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({bus.READY, bus.DATA_ENABLE, bus.DATA_OUT} !== {2'b00, {DW{1'b0}}})
            $display("FAIL arst_outputs: got %b/%b/%h expected 0/0/00", bus.READY, bus.DATA_ENABLE, bus.DATA_OUT);
        else passes++;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_size_zero;
        logic [DW-1:0] exp;
        bit ok;
        int lat, de0;
        de0 = de_count;
        sb.push_back(8'h00);
        do_start(CW'(0));
        wait_ready(ok, lat);
        checks++;
        if (!ok || lat != 0) begin
            $display("FAIL zero_ready: got ok=%0d lat=%0d expected ok=1 lat=0", ok, lat);
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL zero_ready: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (de_count != de0) $display("FAIL zero_no_de: got %0d expected 0", de_count - de0);
        else passes++;
    endtask

    task automatic test_start_ignored;
        logic [DW-1:0] words [4];
        logic [DW-1:0] exp;
        bit ok, all_ok;
        int lat, de0;
        words = '{8'h81, 8'h42, 8'h24, 8'h18};
        de0 = de_count;
        all_ok = 1'b1;
        do_start(CW'(4));
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.START   = 1'b1;
                bus.SIZE_IN = CW'(9);
            end
            if (i == 3) sb.push_back(words[0] ^ words[1] ^ words[2] ^ words[3]);
            feed_word(words[i], 0, ok);
            bus.START = 1'b0;
            all_ok &= ok;
        end
        checks++;
        if (!all_ok) $display("FAIL restart_request: got timeout expected DATA_ENABLE per word");
        else passes++;
        wait_ready(ok, lat);
        checks++;
        if (!ok || lat != 0) begin
            $display("FAIL restart_ready: got ok=%0d lat=%0d expected ok=1 lat=0", ok, lat);
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL restart_data: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (de_count - de0 != 4) $display("FAIL restart_de_pulses: got %0d expected 4", de_count - de0);
        else passes++;
    endtask

    task automatic test_abort;
        logic [DW-1:0] exp;
        bit ok;
        int lat, rc0;
        do_start(CW'(5));
        feed_word(8'h11, 0, ok);
        bus.DATA_IN        = 8'h22;
        bus.DATA_IN_ENABLE = 1'b1;
        #2 RST = 1'b1;
        rc0 = ready_count;
        @(negedge CLK);
        bus.DATA_IN_ENABLE = 1'b0;
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        checks++;
        if (ready_count != rc0) $display("FAIL abort_no_ready: got %0d pulses expected 0", ready_count - rc0);
        else passes++;
        checks++;
        if (bus.DATA_OUT !== 8'h00) $display("FAIL abort_cleared: got %h expected 00", bus.DATA_OUT);
        else passes++;
        do_start(CW'(1));
        sb.push_back(8'h3C);
        feed_word(8'h3C, 0, ok);
        wait_ready(ok, lat);
        checks++;
        if (!ok) begin
            $display("FAIL abort_rerun: got no READY expected pulse");
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL abort_rerun: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp;
        bit ok;
        int lat;
        do_start(CW'(2));
        feed_word(8'h12, 0, ok);
        sb.push_back(8'h12 ^ 8'h34);
        feed_word(8'h34, 0, ok);
        wait_ready(ok, lat);
        checks++;
        if (!ok) begin
            $display("FAIL b2b_first: got no READY expected pulse");
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL b2b_first: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
        do_start(CW'(2));
        feed_word(8'h01, 5, ok);
        checks++;
        if (!ok || bus.DATA_OUT !== 8'h26) $display("FAIL b2b_hold: got %h expected 26", bus.DATA_OUT);
        else passes++;
        sb.push_back(8'h01 ^ 8'h01);
        feed_word(8'h01, 5, ok);
        wait_ready(ok, lat);
        checks++;
        if (!ok) begin
            $display("FAIL b2b_second: got no READY expected pulse");
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL b2b_second: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
    endtask

    task automatic test_max_size;
        logic [DW-1:0] w, acc, exp;
        bit ok, all_ok;
        int lat, de0;
        acc = '0;
        all_ok = 1'b1;
        de0 = de_count;
        do_start({CW{1'b1}});
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            w = DW'($urandom);
            acc ^= w;
            if (i == (1 << CW) - 2) sb.push_back(acc);
            feed_word(w, 0, ok);
            all_ok &= ok;
            if (!ok) break;
        end
        checks++;
        if (!all_ok) $display("FAIL max_request: got timeout expected DATA_ENABLE per word");
        else passes++;
        wait_ready(ok, lat);
        checks++;
        if (!ok) begin
            $display("FAIL max_ready: got no READY expected pulse");
            sb.delete();
        end else begin
            exp = sb.pop_front();
            if (bus.DATA_OUT !== exp) $display("FAIL max_data: got %h expected %h", bus.DATA_OUT, exp);
            else passes++;
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (de_count - de0 != (1 << CW) - 1)
            $display("FAIL max_de_pulses: got %0d expected %0d", de_count - de0, (1 << CW) - 1);
        else passes++;
    endtask

    initial begin
        RST                = 1'b1;
        bus.START          = 1'b0;
        bus.SIZE_IN        = '0;
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = '0;
        repeat (2) @(negedge CLK);
        test_power_on_reset();
        test_basic();
        test_async_reset();
        test_size_zero();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_max_size();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
